// File: rtl/alu_exec_ctrl_if.sv
// Instruction, ALU, write-back and debug bus of the execute/write-back sequencer.
interface alu_exec_ctrl_if;
    logic        ins_valid;
    logic [15:0] ins_word;
    logic        ins_ready;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_arg1;
    logic [15:0] alu_arg2;
    logic [4:0]  alu_in_flg;
    logic [15:0] alu_res;
    logic [4:0]  alu_out_flg;
    logic [4:0]  flags;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    // Sequencer side
    modport slave (
        input  ins_valid, ins_word, alu_res, alu_out_flg, dbg_addr,
        output ins_ready, alu_opcode, alu_arg1, alu_arg2, alu_in_flg,
               flags, wb_valid, wb_addr, wb_data, dbg_data
    );

    // Fetch / ALU / debug side
    modport master (
        output ins_valid, ins_word, alu_res, alu_out_flg, dbg_addr,
        input  ins_ready, alu_opcode, alu_arg1, alu_arg2, alu_in_flg,
               flags, wb_valid, wb_addr, wb_data, dbg_data
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute/write-back sequencer around a 16-bit ALU: 8x16 register file and
// {Z,CY,S,P,OV} flag register, one instruction per three cycles.
module alu_exec_ctrl #(
    parameter logic [4:0] FLAG_RST = 5'b00000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_exec_ctrl_if.slave        bus
);
    localparam int unsigned NREG = 8;
    localparam int unsigned DW   = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   ins_q, ins_d;
    logic [DW-1:0] res_q, res_d;
    logic [4:0]    flg_q, flg_d;
    logic [4:0]    flags_q, flags_d;
    logic [DW-1:0] rf_q [NREG];

    logic          rf_we;
    logic [2:0]    rf_waddr;

    // Instruction field decode of the latched word
    logic       is_ldi;
    logic [2:0] f_op, f_rd, f_rs1, f_rs2, wr_rd;
    logic       f_fwe, f_cin_en, f_nwb;

    assign is_ldi   = ins_q[15];
    assign f_op     = ins_q[14:12];
    assign f_rd     = ins_q[11:9];
    assign f_rs1    = ins_q[8:6];
    assign f_rs2    = ins_q[5:3];
    assign f_fwe    = ins_q[2];
    assign f_cin_en = ins_q[1];
    assign f_nwb    = ins_q[0];
    assign wr_rd    = is_ldi ? ins_q[14:12] : f_rd;

    // Sequencer state, captured ALU result and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ins_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            flags_q <= FLAG_RST;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            flags_q <= flags_d;
        end
    end

    // Register file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q <= '{default: '0};
        end else if (rf_we) begin
            rf_q[rf_waddr] <= res_q;
        end
    end

    // Next-state, ALU drive, write-back and flag update
    always_comb begin
        state_d         = state_q;
        ins_d           = ins_q;
        res_d           = res_q;
        flg_d           = flg_q;
        flags_d         = flags_q;
        rf_we           = 1'b0;
        rf_waddr        = wr_rd;
        bus.ins_ready   = 1'b0;
        bus.alu_opcode  = 3'b110;
        bus.alu_arg1    = '0;
        bus.alu_arg2    = '0;
        bus.alu_in_flg  = flags_q;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;

        case (state_q)
            S_IDLE: begin
                bus.ins_ready = 1'b1;
                if (bus.ins_valid) begin
                    ins_d   = bus.ins_word;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_ldi) begin
                    res_d = DW'(ins_q[11:0]);
                end else begin
                    bus.alu_opcode = f_op;
                    bus.alu_arg1   = rf_q[f_rs1];
                    bus.alu_arg2   = rf_q[f_rs2];
                    bus.alu_in_flg = {flags_q[4], flags_q[3] & f_cin_en, flags_q[2:0]};
                    res_d          = bus.alu_res;
                end
                flg_d   = bus.alu_out_flg;
                state_d = S_WB;
            end
            S_WB: begin
                if (is_ldi || !f_nwb) begin
                    rf_we        = 1'b1;
                    bus.wb_valid = 1'b1;
                    bus.wb_addr  = wr_rd;
                    bus.wb_data  = res_q;
                end
                // CY/OV only come from arithmetic ops; pass-through CY is undefined
                if (!is_ldi && f_fwe) begin
                    case (f_op)
                        3'b000, 3'b001: flags_d = flg_q;
                        3'b110, 3'b111: flags_d = {flg_q[4], flags_q[3], flg_q[2:1], flags_q[0]};
                        default:        flags_d = {flg_q[4], 1'b0, flg_q[2:1], flags_q[0]};
                    endcase
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.flags    = flags_q;
    assign bus.dbg_data = rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized bench for alu_exec_ctrl with an ALU stub and an instruction-level model.
module tb_alu_exec_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl #(.FLAG_RST(5'b00000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] ref_rf [8];
    logic [4:0]  ref_flags;

    // Behavioural 16-bit ALU: {Z,CY,S,P,OV,res}; non-arithmetic CY/OV are junk
    function automatic logic [20:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [16:0] w;
        logic [15:0] r;
        logic        cy, ov;
        w  = '0;
        cy = ^(a ^ {b[7:0], b[15:8]}) ^ op[0];
        ov = ~(a[3] ^ b[11]);
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b} + 17'(cin);
                r = w[15:0]; cy = w[16];
                ov = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b} - 17'(cin);
                r = w[15:0]; cy = w[16];
                ov = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~a;
            3'd6:    r = a;
            default: r = b;
        endcase
        return {r == 16'h0, cy, r[15], ^r, ov, r};
    endfunction

    // ALU stub
    always_comb begin
        {bus.alu_out_flg, bus.alu_res} = alu_fn(bus.alu_opcode, bus.alu_arg1,
                                                bus.alu_arg2, bus.alu_in_flg[3]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0;
        ref_flags = 5'b00000;
    endtask

    // Issue one instruction from an IDLE negedge and check every phase
    task automatic do_ins(input logic [15:0] w);
        logic        ldi, we;
        logic [2:0]  op, rd, rs1, rs2;
        logic [20:0] a;
        logic [15:0] res;
        logic [4:0]  nf;
        int          n;
        n = 0;
        while (!bus.ins_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.ins_ready), 32'd1);
        ldi = w[15];
        op  = w[14:12];
        rd  = ldi ? w[14:12] : w[11:9];
        rs1 = w[8:6];
        rs2 = w[5:3];
        a   = alu_fn(op, ref_rf[rs1], ref_rf[rs2], ref_flags[3] & w[1]);
        res = ldi ? {4'h0, w[11:0]} : a[15:0];
        we  = ldi || !w[0];
        nf  = ref_flags;
        if (!ldi && w[2]) begin
            nf[4] = a[20];
            nf[2] = a[18];
            nf[1] = a[17];
            if (op < 3'd2)      begin nf[3] = a[19]; nf[0] = a[16]; end
            else if (op < 3'd6) nf[3] = 1'b0;
        end
        bus.ins_valid = 1'b1;
        bus.ins_word  = w;
        @(negedge clk);
        bus.ins_valid = 1'($urandom);
        bus.ins_word  = 16'($urandom);
        chk("exec_ready", 32'(bus.ins_ready), 32'd0);
        chk("exec_wbv", 32'(bus.wb_valid), 32'd0);
        if (!ldi) begin
            chk("exec_op", 32'(bus.alu_opcode), 32'(op));
            chk("exec_arg1", 32'(bus.alu_arg1), 32'(ref_rf[rs1]));
            chk("exec_arg2", 32'(bus.alu_arg2), 32'(ref_rf[rs2]));
            chk("exec_inflg", 32'(bus.alu_in_flg),
                32'({ref_flags[4], ref_flags[3] & w[1], ref_flags[2:0]}));
        end
        @(negedge clk);
        bus.ins_valid = 1'b0;
        chk("wb_ready", 32'(bus.ins_ready), 32'd0);
        chk("wb_valid", 32'(bus.wb_valid), 32'(we));
        chk("wb_addr", 32'(bus.wb_addr), we ? 32'(rd) : 32'd0);
        chk("wb_data", 32'(bus.wb_data), we ? 32'(res) : 32'd0);
        bus.dbg_addr = rd;
        if (we) ref_rf[rd] = res;
        ref_flags = nf;
        @(negedge clk);
        chk("idle_ready", 32'(bus.ins_ready), 32'd1);
        chk("idle_op", 32'(bus.alu_opcode), 32'd6);
        chk("idle_arg1", 32'(bus.alu_arg1), 32'd0);
        chk("flags", 32'(bus.flags), 32'(ref_flags));
        chk("dbg_rd", 32'(bus.dbg_data), 32'(ref_rf[rd]));
    endtask

    initial begin
        int cnt;
        logic [15:0] w;
        rst_n         = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins_word  = 16'h0;
        bus.dbg_addr  = 3'd0;
        ref_reset();
        #1;
        chk("rst_ready", 32'(bus.ins_ready), 32'd1);
        chk("rst_wbv", 32'(bus.wb_valid), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Put state in place, then reset in the middle of an LDI
        do_ins(16'h9FFF);
        do_ins(16'h5444);
        chk("pre_rst_flags", 32'(bus.flags), 32'h04);
        bus.ins_valid = 1'b1;
        bus.ins_word  = 16'h9123;
        bus.dbg_addr  = 3'd1;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.ins_ready), 32'd1);
        chk("mid_rst_wbv", 32'(bus.wb_valid), 32'd0);
        chk("mid_rst_flags", 32'(bus.flags), 32'd0);
        chk("mid_rst_r1", 32'(bus.dbg_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_reset();
        @(negedge clk);
        chk("post_rst_r1", 32'(bus.dbg_data), 32'd0);
        bus.dbg_addr = 3'd2;
        #1;
        chk("post_rst_r2", 32'(bus.dbg_data), 32'd0);

        // Continuous valid: one acceptance every three cycles
        cnt = 0;
        bus.ins_valid = 1'b1;
        bus.ins_word  = 16'hA055;
        for (int i = 0; i < 9; i++) begin
            if (bus.ins_ready) cnt++;
            if (i == 8) bus.ins_valid = 1'b0;
            @(negedge clk);
        end
        chk("accept_cnt", 32'(cnt), 32'd3);
        ref_rf[2] = 16'h0055;
        chk("held_r2", 32'(bus.dbg_data), 32'h0055);

        // Directed sequence
        do_ins(16'h9FFF);
        chk("ldi_r1", 32'(bus.dbg_data), 32'h0FFF);
        do_ins(16'hA001);
        chk("ldi_r2", 32'(bus.dbg_data), 32'h0001);
        chk("ldi_flags", 32'(bus.flags), 32'h00);
        do_ins(16'h5604);
        chk("not_r3", 32'(bus.dbg_data), 32'hFFFF);
        chk("not_flags", 32'(bus.flags), 32'h04);
        do_ins(16'h0ED4);
        chk("add_r7", 32'(bus.dbg_data), 32'h0000);
        chk("add_flags", 32'(bus.flags), 32'h18);
        do_ins(16'h0C06);
        chk("cin_r6", 32'(bus.dbg_data), 32'h0001);
        chk("cin_flags", 32'(bus.flags), 32'h02);
        do_ins(16'h0C04);
        chk("nocin_r6", 32'(bus.dbg_data), 32'h0000);
        chk("nocin_flags", 32'(bus.flags), 32'h10);
        do_ins(16'h1A4D);
        chk("cmp_r5", 32'(bus.dbg_data), 32'h0000);
        chk("cmp_zcy", 32'(bus.flags[4:3]), 32'h2);
        do_ins(16'h0ED4);
        do_ins(16'h6A44);
        chk("pass_r5", 32'(bus.dbg_data), 32'h0FFF);
        chk("pass_flags", 32'(bus.flags), 32'h08);

        // Random instruction stream with idle gaps
        for (int k = 0; k < 150; k++) begin
            w = 16'($urandom);
            if (w[15] && w[11:8] == 4'h0) w[11:8] = 4'(k);
            do_ins(w);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                bus.ins_word = 16'($urandom);
                @(negedge clk);
            end
        end

        // Final register-file sweep
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            chk("final_rf", 32'(bus.dbg_data), 32'(ref_rf[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
